// File: rtl/main_decoder_mc_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : main_decoder_mc_gen
// Purpose  : Multicycle RV32I main control FSM with memory handshake, trap
//            state and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module main_decoder_mc_gen #(
    parameter int MEM_WAIT  = 1,
    parameter int TRAP_HOLD = 1,
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 mem_ready,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic                 RegWrite,
    output logic                 PCUpdate,
    output logic                 AddrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 Branch,
    output logic [2:0]           BrType,
    output logic                 illegal,
    output logic                 retire,
    output logic [RET_CNT_W-1:0] ret_cnt,
    output logic [3:0]           state_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_LUI      = 4'd8;
    localparam logic [3:0] S_AUIPC    = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALRLNK  = 4'd12;
    localparam logic [3:0] S_ALUWB    = 4'd13;
    localparam logic [3:0] S_BRANCH   = 4'd14;
    localparam logic [3:0] S_TRAP     = 4'd15;

    logic [3:0]           r_state;
    logic [3:0]           w_next;
    logic [RET_CNT_W-1:0] r_ret_cnt;
    logic                 w_hs;
    logic                 w_br_ok;
    logic                 w_regwrite, w_pcupdate, w_addrsrc, w_memwrite;
    logic                 w_irwrite, w_branch, w_retire;

    assign w_hs    = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    // funct3 010/011 are unassigned branch encodings
    assign w_br_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_hs ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    7'h03, 7'h23: w_next = S_MEMADR;
                    7'h33:        w_next = S_EXECR;
                    7'h13:        w_next = S_EXECI;
                    7'h6F:        w_next = S_JAL;
                    7'h67:        w_next = (funct3 == 3'b000) ? S_JALR : S_TRAP;
                    7'h37:        w_next = S_LUI;
                    7'h17:        w_next = S_AUIPC;
                    7'h63:        w_next = w_br_ok ? S_BRANCH : S_TRAP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (opcode == 7'h03) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = w_hs ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_hs ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_LUI:      w_next = S_ALUWB;
            S_AUIPC:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JALRLNK;
            S_JALRLNK:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_TRAP:     w_next = (TRAP_HOLD != 0) ? S_TRAP : S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        BrType     = 3'b000;
        illegal    = 1'b0;
        w_regwrite = 1'b0;
        w_pcupdate = 1'b0;
        w_addrsrc  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_branch   = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ResultSrc  = 2'b10;
                ALUSrcB    = 2'b10;
                w_irwrite  = w_hs;
                w_pcupdate = w_hs;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  w_addrsrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWRITE: begin
                w_addrsrc  = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = w_hs;
            end
            S_EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
            S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
            S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
            S_AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_JAL, S_JALRLNK: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_ALUWB:    begin w_regwrite = 1'b1; w_retire = 1'b1; end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                BrType   = funct3;
                w_branch = 1'b1;
                w_retire = 1'b1;
            end
            S_TRAP:     illegal = 1'b1;
            default:    ;
        endcase
    end

    // Strobes are forced low combinationally while reset is held
    assign RegWrite = w_regwrite & reset;
    assign PCUpdate = w_pcupdate & reset;
    assign AddrSrc  = w_addrsrc  & reset;
    assign MemWrite = w_memwrite & reset;
    assign IRWrite  = w_irwrite  & reset;
    assign Branch   = w_branch   & reset;
    assign retire   = w_retire   & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret_cnt <= '0;
        end else if (w_retire) begin
            r_ret_cnt <= r_ret_cnt + {{(RET_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ret_cnt = r_ret_cnt;
    assign state_o = r_state;

endmodule
`default_nettype wire
